// File: rtl/spi_ram_bridge_pkg.sv
// Shared encodings for the SPI SRAM bridge: bus FSM states, SPI opcodes and frame sizes.
// No logic; imported by the bridge top and its shifter.
package spi_ram_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XFER,
        ST_DONE,
        ST_CSHIGH,
        ST_HOLD
    } state_t;

    localparam logic [7:0] SPI_OP_READ  = 8'h03;
    localparam logic [7:0] SPI_OP_WRITE = 8'h02;

    // Full frame is opcode, address high, address low, data; a streamed read moves one data byte.
    localparam int FRAME_BITS = 32;
    localparam int SEQ_BITS   = 8;

endpackage

// File: rtl/spi_shifter.sv
// SPI mode-0 master shifter: SCK divider, bit counter, MSB-first shift with MISO captured into the LSB.
// Latency: 2*SCK_HALF_CYCLES clk cycles per bit; done is combinational on the edge of the last falling SCK.
// Backpressure: none; start is only honoured by the owner while idle, and a running frame cannot be stalled.
module spi_shifter #(
    parameter int unsigned SCK_HALF_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  nbits,
    input  logic [31:0] word,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rx_byte
);

    localparam logic [3:0] DIV_LAST = 4'(SCK_HALF_CYCLES - 1);

    logic [31:0] sr;
    logic [5:0]  bits_left;
    logic [3:0]  div;
    logic        phase_end;

    assign phase_end = busy && (div == DIV_LAST);
    assign done      = phase_end && sck && (bits_left == 6'd1);
    assign rx_byte   = sr[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            sr        <= '0;
            bits_left <= '0;
            div       <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            sck       <= 1'b0;
            mosi      <= word[31];
            sr        <= word;
            bits_left <= nbits;
            div       <= '0;
        end else if (busy) begin
            if (phase_end) begin
                div <= '0;
                sck <= !sck;
                if (!sck) begin
                    sr <= {sr[30:0], miso};
                end else begin
                    // MOSI only moves with the falling edge, so it is stable through the high phase.
                    bits_left <= bits_left - 6'd1;
                    if (bits_left == 6'd1) begin
                        busy <= 1'b0;
                        mosi <= 1'b0;
                    end else begin
                        mosi <= sr[31];
                    end
                end
            end else begin
                div <= div + 4'd1;
            end
        end
    end

endmodule

// File: rtl/spi_ram_bridge.sv
// CPU bus responder backed by a 23LC512 SPI SRAM; optional read streaming under SPI_RAM_BRIDGE_SEQ_READ_EN.
// Latency: 64*SCK_HALF_CYCLES cycles of transfer per access (16*SCK_HALF_CYCLES for a streamed sequential read).
// Backpressure: bus_wait stays high combinationally from the request until the transfer completes.
module spi_ram_bridge #(
    parameter int unsigned SCK_HALF_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_address,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic        bus_wait,
    output logic [7:0]  bus_rdata,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    import spi_ram_bridge_pkg::*;

    state_t      state, state_nxt;
    logic        is_write;
    logic        req;
    logic        xfer_start;
    logic [5:0]  xfer_bits;
    logic [31:0] xfer_word;
    logic        xfer_busy;
    logic        xfer_done;
    logic [7:0]  xfer_byte;

    assign req      = bus_read | bus_write;
    assign bus_wait = req && (state != ST_DONE);

`ifdef SPI_RAM_BRIDGE_SEQ_READ_EN
    logic [15:0] last_addr;
    logic        seq_hit;

    // The RAM's internal pointer wraps at 0xFFFF, but a wrap is treated as a fresh access.
    assign seq_hit = bus_read && !bus_write && (last_addr != 16'hFFFF)
                     && (bus_address == last_addr + 16'd1);
`endif

    always_comb begin
        state_nxt  = state;
        xfer_start = 1'b0;
        xfer_bits  = 6'(FRAME_BITS);
        xfer_word  = {bus_write ? SPI_OP_WRITE : SPI_OP_READ, bus_address,
                      bus_write ? bus_wdata : 8'h00};
        case (state)
            ST_IDLE: begin
                if (req) begin
                    xfer_start = 1'b1;
                    state_nxt  = ST_XFER;
                end
            end
            ST_XFER: begin
                if (xfer_done || !xfer_busy) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (!req) begin
`ifdef SPI_RAM_BRIDGE_SEQ_READ_EN
                    state_nxt = is_write ? ST_CSHIGH : ST_HOLD;
`else
                    state_nxt = ST_CSHIGH;
`endif
                end
            end
            ST_CSHIGH: state_nxt = ST_IDLE;
`ifdef SPI_RAM_BRIDGE_SEQ_READ_EN
            ST_HOLD: begin
                if (req) begin
                    if (seq_hit) begin
                        xfer_start = 1'b1;
                        xfer_bits  = 6'(SEQ_BITS);
                        xfer_word  = '0;
                        state_nxt  = ST_XFER;
                    end else begin
                        state_nxt  = ST_CSHIGH;
                    end
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            spi_cs_n  <= 1'b1;
            bus_rdata <= 8'h00;
            is_write  <= 1'b0;
        end else begin
            state    <= state_nxt;
            spi_cs_n <= !(state_nxt inside {ST_XFER, ST_DONE, ST_HOLD});
            if (xfer_start) is_write <= bus_write;
            if ((state == ST_XFER) && xfer_done && !is_write) bus_rdata <= xfer_byte;
        end
    end

`ifdef SPI_RAM_BRIDGE_SEQ_READ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr <= 16'h0000;
        end else if (xfer_start) begin
            last_addr <= bus_address;
        end
    end
`endif

    spi_shifter #(
        .SCK_HALF_CYCLES(SCK_HALF_CYCLES)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .start   (xfer_start),
        .nbits   (xfer_bits),
        .word    (xfer_word),
        .miso    (spi_miso),
        .sck     (spi_sck),
        .mosi    (spi_mosi),
        .busy    (xfer_busy),
        .done    (xfer_done),
        .rx_byte (xfer_byte)
    );

endmodule

// File: doc/spi_ram_bridge.md
# spi_ram_bridge

Bus responder that serves the CPU's memory bus (`bus_address_out`/`bus_data_out`/`bus_read`/`bus_write`/`bus_wait`/`bus_data_in`) from an external 23LC512-class SPI SRAM (64 KiB, 16-bit address, sequential mode). It converts each CPU read or write into an SPI READ (0x03) or WRITE (0x02) transaction. It holds `bus_wait` high until the transaction completes. It sits between the CPU and the chip's SPI pins.

## Interface
- `SCK_HALF_CYCLES`, 1: clk cycles per SCK half-period; legal range 1..15.
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `bus_address` input 16: byte address from the CPU.
- `bus_wdata` input 8: write data from the CPU.
- `bus_read` input 1: read request level, held until acknowledged.
- `bus_write` input 1: write request level, held until acknowledged.
- `bus_wait` output 1: combinational; high while a request is pending and not complete.
- `bus_rdata` output 8: read data register, drives the CPU's `bus_data_in`.
- `spi_cs_n` output 1: SPI chip select, active low.
- `spi_sck` output 1: SPI clock, mode 0.
- `spi_mosi` output 1: SPI data to the RAM.
- `spi_miso` input 1: SPI data from the RAM; treated as synchronous to `clk`.

## Operation
- Reset values: `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `bus_rdata`=0x00, state=IDLE.
- `bus_wait` = (`bus_read` | `bus_write`) & (state != DONE). It is high in the same cycle a request first appears, because the CPU samples it on the very next edge.
- States and transitions:
  - IDLE: on a request, latch address, data and direction. Drive `spi_cs_n` low. Load a 32-bit shift register with {opcode, addr[15:8], addr[7:0], wdata-or-0x00}. Go to XFER.
  - XFER: shift 32 bits MSB-first, SPI mode 0.
    - MOSI changes only while SCK is low.
    - MISO is sampled on each SCK rising edge into the shift LSB.
    - After the 32nd falling edge, go to DONE. For a read, `bus_rdata` then holds the last 8 sampled bits.
  - DONE: `bus_wait` low. Stay until both `bus_read` and `bus_write` are low, then go to CSHIGH.
  - CSHIGH: `spi_cs_n` high for exactly 1 cycle, then IDLE.
- `bus_rdata` changes only on read completion. It holds across writes and idle time, because the CPU consumes it after dropping `bus_read`.
- If `bus_read` and `bus_write` are both high at acceptance, the write is performed and the read is ignored.
- A request that changes or drops mid-XFER is ignored; the latched transaction completes.
- `rst` asserted mid-transaction: next edge returns to reset values and IDLE. A pending request sees `bus_wait` high and restarts from scratch after reset releases.

## Timing
- With SCK_HALF_CYCLES=1, let A be the accepting edge (IDLE sees a request):
  - At A: `spi_cs_n`=0, `spi_sck`=0, `spi_mosi`=bit 31.
  - Rising SCK edges at A+1, A+3, … A+63.
  - DONE is entered at A+64; `bus_wait` is low from A+64.
  - For the CPU: request raised → data captured 66 edges later, when DONE is sampled.
- General case: XFER lasts 64·SCK_HALF_CYCLES cycles.
- Back-to-back requests: minimum one CSHIGH cycle plus one IDLE cycle between transactions.

## Configuration
- `SPI_RAM_BRIDGE_SEQ_READ_EN` defined:
  - After a read, DONE exits to HOLD instead of CSHIGH. HOLD keeps `spi_cs_n` low and `spi_sck` low.
  - A read at latched_addr+1 is served by shifting 8 data bits only: DONE at A+16 for SCK_HALF_CYCLES=1.
  - A write, a non-sequential read, or a read at 0x0000 following 0xFFFF goes HOLD → CSHIGH → IDLE, then runs a full transaction.
- `SPI_RAM_BRIDGE_SEQ_READ_EN` undefined: HOLD does not exist; every transaction is a full 32-bit one.

## Structure
- Package `spi_ram_bridge_pkg`: state encoding (IDLE, XFER, DONE, CSHIGH, HOLD), opcodes SPI_OP_READ=8'h03 and SPI_OP_WRITE=8'h02, and the 32-bit frame width constant.
- Sub-module `spi_shifter`: shift register, SCK divider and bit counter. Interface: start, bit count (32 or 8), load word, busy/done, captured byte. The top level owns the bus FSM.

## Test plan
- Read 0x1234 with the RAM model holding 0xA5:
  - MOSI frame is 0x03,0x12,0x34,0x00.
  - `bus_wait` is high from the request until A+64.
  - `bus_rdata`=0xA5 and holds after `bus_read` drops.
- Write 0x5A to 0xBEEF: MOSI frame is 0x02,0xBE,0xEF,0x5A; the model stores 0x5A; `bus_rdata` is unchanged.
- Reset asserted at A+20 of a read: next edge gives `spi_cs_n`=1, `spi_sck`=0 and the model sees an aborted frame; after release, the held request completes normally.
- `bus_read` and `bus_write` both high: a write frame is issued.
- SCK_HALF_CYCLES=3: DONE at A+192; SCK high and low phases are each 3 cycles.
- With SEQ_READ_EN:
  - Reads at 0x0010 then 0x0011 → second completes at A+16 with no CS toggle.
  - Reads at 0xFFFF then 0x0000 → CS toggles and a full frame is sent.
